iob_native_axi_master: RTL and testbench

- Initiator-side bridge: converts one native-bus request (valid/addr/wdata/wstrb/rdata/ready) into a single-beat AXI4 master transaction.
- Drives an AXI4 memory responder, e.g. the DDR model RAM in simulation or the DDR controller on FPGA.
- Lets a tester or peripheral reach external memory without a cache.
- One outstanding transaction at a time; no bursts.

---
 rtl/iob_native_axi_master.sv | 164 ++++++++++++++++
 tb/tb_iob_native_axi_master.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/iob_native_axi_master.sv
// Native valid/ready request to single-beat AXI4 master bridge.
// One outstanding transaction; the request is latched on acceptance.
module iob_native_axi_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                err,
  output logic                m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic [3:0]          m_axi_awqos,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic                m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arlock,
  output logic [3:0]          m_axi_arcache,
  output logic [2:0]          m_axi_arprot,
  output logic [3:0]          m_axi_arqos,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;

  // Single-beat, word-sized, INCR, normal non-cacheable bufferable
  assign m_axi_awid    = 1'b0;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'd2;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_arid    = 1'b0;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'd2;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arqos   = 4'd0;
  assign m_axi_wlast   = 1'b1;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;

  // Byte-offset bits and rlast carry no information for single word beats
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], m_axi_rlast};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ready         <= 1'b0;
      err           <= 1'b0;
      rdata         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            addr_q  <= {addr[ADDR_W-1:2], 2'b00};
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            if (wstrb != '0) begin
              state         <= WRITE;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
            end else begin
              state         <= READ;
              m_axi_arvalid <= 1'b1;
            end
          end
        end
        WRITE: begin
          // A dropped valid marks its channel as already handshaken
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready) m_axi_wvalid <= 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            state        <= WRESP;
            m_axi_bready <= 1'b1;
          end
        end
        WRESP: begin
          if (m_axi_bvalid) begin
            state        <= DONE;
            m_axi_bready <= 1'b0;
            err          <= (m_axi_bresp != 2'b00);
            ready        <= 1'b1;
          end
        end
        READ: begin
          if (m_axi_arready) begin
            state         <= RDATA;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
          end
        end
        RDATA: begin
          if (m_axi_rvalid) begin
            state        <= DONE;
            m_axi_rready <= 1'b0;
            rdata        <= m_axi_rdata;
            err          <= (m_axi_rresp != 2'b00);
            ready        <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_native_axi_master.sv
// Directed bench: native requests against a small AXI responder with stall and error injection.
module tb_iob_native_axi_master;

  logic        clk, rst;
  logic        valid, ready, err;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wstrb;
  logic        awid, awlock, awvalid, awready;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  awcache, awqos, arcache, arqos;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        wlast, wvalid, wready, bvalid, bready;
  logic        arid, arlock, arvalid, arready, rlast, rvalid, rready;

  iob_native_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready), .err(err),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
    .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rdata(m_rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: word memory, AW stall counter, R hold and SLVERR injection
  logic [31:0] mem [0:63];
  int          aw_wait, aw_cnt;
  logic        r_err, r_hold;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [31:0] aw_a, w_d, r_d;
  logic [3:0]  w_s;
  logic [1:0]  r_resp;
  logic        aw_hs, w_hs, ar_hs, have_a, have_w;
  logic [31:0] a_now, d_now;
  logic [3:0]  s_now;

  assign awready = (aw_cnt >= aw_wait);
  assign wready  = 1'b1;
  assign arready = 1'b1;
  assign bvalid  = b_pend;
  assign bresp   = 2'b00;
  assign rvalid  = r_pend && !r_hold;
  assign m_rdata = r_d;
  assign rresp   = r_resp;
  assign rlast   = 1'b1;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;
  assign have_a  = aw_got || aw_hs;
  assign have_w  = w_got || w_hs;
  assign a_now   = aw_got ? aw_a : awaddr;
  assign d_now   = w_got ? w_d : m_wdata;
  assign s_now   = w_got ? w_s : m_wstrb;

  always @(posedge clk) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0;
      b_pend <= 1'b0; r_pend <= 1'b0; r_d <= '0; r_resp <= 2'b00;
    end else begin
      if (aw_hs) begin aw_got <= 1'b1; aw_a <= awaddr; aw_cnt <= 0; end
      else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin w_got <= 1'b1; w_d <= m_wdata; w_s <= m_wstrb; end
      if (have_a && have_w) begin
        for (int i = 0; i < 4; i++)
          if (s_now[i]) mem[a_now[7:2]][8*i +: 8] <= d_now[8*i +: 8];
        b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (b_pend && bready) b_pend <= 1'b0;
      if (ar_hs) begin
        r_pend <= 1'b1;
        r_d    <= mem[araddr[7:2]];
        r_resp <= r_err ? 2'b10 : 2'b00;
      end
      if (rvalid && rready) r_pend <= 1'b0;
    end
  end

  // Monitor: handshake captures and per-signal activity counters
  int          ready_cnt, b_cnt, awv_cyc, wv_cyc;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  logic        cap_wlast;
  logic [7:0]  cap_arlen;
  logic [2:0]  cap_arsize;

  initial begin ready_cnt = 0; b_cnt = 0; awv_cyc = 0; wv_cyc = 0; end
  always @(posedge clk) begin
    if (ready) ready_cnt <= ready_cnt + 1;
    if (bvalid && bready) b_cnt <= b_cnt + 1;
    if (awvalid) awv_cyc <= awv_cyc + 1;
    if (wvalid) wv_cyc <= wv_cyc + 1;
    if (aw_hs) cap_awaddr <= awaddr;
    if (w_hs) begin cap_wdata <= m_wdata; cap_wstrb <= m_wstrb; cap_wlast <= wlast; end
    if (ar_hs) begin cap_araddr <= araddr; cap_arlen <= arlen; cap_arsize <= arsize; end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_wait;
    logic        r_err;
    logic [31:0] exp_axaddr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int cyc, rc0, b0, awv0, wv0;
    logic is_wr;
    is_wr = (v.wstrb != 4'h0);
    aw_wait = v.aw_wait;
    r_err   = v.r_err;
    rc0 = ready_cnt; b0 = b_cnt; awv0 = awv_cyc; wv0 = wv_cyc;
    addr = v.addr; wdata = v.wdata; wstrb = v.wstrb; valid = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    while (!ready && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(v.exp_lat));
    chk({tag, "_err"}, 64'(err), 64'(v.exp_err));
    if (is_wr) begin
      chk({tag, "_awaddr"}, 64'(cap_awaddr), 64'(v.exp_axaddr));
      chk({tag, "_wdata"}, 64'(cap_wdata), 64'(v.wdata));
      chk({tag, "_wstrb"}, 64'(cap_wstrb), 64'(v.wstrb));
      chk({tag, "_wlast"}, 64'(cap_wlast), 64'd1);
      chk({tag, "_awvalid_cycles"}, 64'(awv_cyc - awv0), 64'(v.aw_wait + 1));
      chk({tag, "_wvalid_cycles"}, 64'(wv_cyc - wv0), 64'd1);
    end else begin
      chk({tag, "_araddr"}, 64'(cap_araddr), 64'(v.exp_axaddr));
      chk({tag, "_arlen_size"}, 64'({cap_arlen, 5'd0, cap_arsize}), 64'h2);
      chk({tag, "_rdata"}, 64'(rdata), 64'(v.exp_rdata));
    end
    valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_ready_drop"}, 64'(ready), 64'd0);
    chk({tag, "_ready_pulses"}, 64'(ready_cnt - rc0), 64'd1);
    chk({tag, "_b_count"}, 64'(b_cnt - b0), 64'(is_wr));
  endtask

  vec_t vecs [9];

  initial begin
    int rc0, cyc;
    vecs[0] = '{32'h100, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h100, 32'h0,        1'b0, 3};
    vecs[1] = '{32'h100, 32'h0,        4'h0, 0, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 3};
    vecs[2] = '{32'h104, 32'h11223344, 4'hF, 0, 1'b0, 32'h104, 32'h0,        1'b0, 3};
    vecs[3] = '{32'h107, 32'h0000AB00, 4'h2, 0, 1'b0, 32'h104, 32'h0,        1'b0, 3};
    vecs[4] = '{32'h104, 32'h0,        4'h0, 0, 1'b0, 32'h104, 32'h1122AB44, 1'b0, 3};
    vecs[5] = '{32'h100, 32'h0,        4'h0, 0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 3};
    vecs[6] = '{32'h104, 32'h0,        4'h0, 0, 1'b0, 32'h104, 32'h1122AB44, 1'b0, 3};
    vecs[7] = '{32'h108, 32'hCAFEF00D, 4'hF, 4, 1'b0, 32'h108, 32'h0,        1'b0, 7};
    vecs[8] = '{32'h10B, 32'h0,        4'h0, 0, 1'b0, 32'h108, 32'hCAFEF00D, 1'b0, 3};

    rst = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    aw_wait = 0; r_err = 1'b0; r_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ctrl", 64'({ready, err, awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    chk("reset_rdata", 64'(rdata), 64'd0);
    chk("const_aw", 64'({awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos}),
        64'({1'b0, 8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0}));
    chk("const_ar", 64'({arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos}),
        64'({1'b0, 8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0}));
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // rdata persists after the read that produced it
    repeat (4) @(posedge clk);
    #1 chk("rdata_hold", 64'(rdata), 64'hCAFEF00D);

    // Reset while waiting for R: abandon without a completion pulse
    r_hold = 1'b1; aw_wait = 0; r_err = 1'b0;
    rc0 = ready_cnt;
    addr = 32'h100; wstrb = 4'h0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    cyc = 0;
    while (!rready && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_mid_rready", 64'({rready, arvalid}), 64'b10);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_mid_ctrl", 64'({ready, err, awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    chk("rst_mid_rdata", 64'(rdata), 64'd0);
    r_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("rst_mid_no_pulse", 64'(ready_cnt - rc0), 64'd0);
    run_vec(vecs[1], "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
